// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX FIFO write port among N_REQ byte-stream requesters.
// Packet-granular round-robin grant, optional channel-ID header byte, forced release of stalled owners.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_EN   = 1,
  parameter int TIMEOUT = 1024,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 fifo_wr,
  output logic [7:0]           fifo_data,
  input  logic                 fifo_full,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int             CW      = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  TLIM    = CW'(TIMEOUT - 1);
  localparam logic [IDW:0]   NR      = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  tcnt;

  logic           any_valid;
  logic [IDW-1:0] pick;
  logic [IDW:0]   sum;
  logic           own_valid;
  logic           own_last;
  logic [7:0]     own_data;
  logic [IDW-1:0] next_ptr;
  logic           xfer;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    any_valid = 1'b0;
    pick      = '0;
    sum       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= NR) sum = sum - NR;
      if (req_valid[sum[IDW-1:0]]) begin
        any_valid = 1'b1;
        pick      = sum[IDW-1:0];
      end
    end
  end

  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign own_data  = req_data[{grant_id, 3'b000} +: 8];
  assign next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
  assign xfer      = (state == DATA) && fifo_wr;
  assign busy      = (state != IDLE);

  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_data = '0;
    case (state)
      HDR: begin
        fifo_data = {4'hA, 1'b0, 3'(grant_id)};
        fifo_wr   = !fifo_full;
      end
      DATA: begin
        req_ready[grant_id] = !fifo_full;
        fifo_wr             = own_valid && !fifo_full;
        fifo_data           = own_data;
      end
      default: ;
    endcase
  end

  // A full FIFO with the owner valid is not a stall, so only !own_valid advances the counter.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      tcnt          <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            tcnt     <= '0;
            state    <= (ID_EN != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (!fifo_full) begin
            tcnt  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            tcnt <= '0;
            if (own_last) begin
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end else if (!own_valid) begin
            if (tcnt == TLIM) begin
              timeout_pulse <= 1'b1;
              rr_ptr        <= next_ptr;
              state         <= IDLE;
            end else if (tcnt != '1) begin
              tcnt <= tcnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit FIFO write port among N_REQ byte-stream requesters, e.g. CPU console, debug tracer and DMA log.
- Grants at packet granularity with round-robin fairness and optionally prepends a channel-ID header byte.
- Sits between the requesters and the UART TX FIFO write side, in the Clk domain.
- Forcibly releases a grant whose owner stalls for too long.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ID_EN, 1: 1 = emit header byte {4'hA, 1'b0, id[2:0]} before each packet; 0 = no header.
- TIMEOUT, 1024: consecutive DATA-state cycles with the owner not valid before forced release; minimum 2.
- IDW, $clog2(N_REQ): width of grant_id.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  marks the final byte of a packet; qualified by valid.
- req_ready  out  N_REQ  byte accepted this cycle, per requester.
- fifo_wr  out  1  write strobe to the UART TX FIFO.
- fifo_data  out  8  byte to the UART TX FIFO.
- fifo_full  in  1  UART TX FIFO full.
- grant_id  out  IDW  current or last owner.
- busy  out  1  high in HDR and DATA states.
- timeout_pulse  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (synchronous, Rst high at a Clk edge):
  - state = IDLE, rr_ptr = 0, grant_id = 0, timeout counter = 0.
  - Outputs: busy = 0, timeout_pulse = 0, fifo_wr = 0, fifo_data = 0, req_ready = 0.
  - Reset mid-packet abandons the packet with no further writes; the requester's remaining bytes are not consumed.
- State IDLE:
  - fifo_wr = 0, req_ready = 0.
  - If any req_valid: select the first valid index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Register grant_id, then go to HDR if ID_EN, else DATA. The grant is visible the cycle after valid is seen.
- State HDR:
  - fifo_data = {4'hA, 1'b0, grant_id padded to 3 bits}.
  - fifo_wr = !fifo_full (combinational).
  - On the write, go to DATA; while full, hold.
- State DATA (combinational outputs for owner g):
  - req_ready[g] = !fifo_full; all other ready bits = 0.
  - fifo_wr = req_valid[g] & !fifo_full.
  - fifo_data = req_data[g].
- Transfer = fifo_wr in DATA.
  - Transfer with req_last[g]: go to IDLE and set rr_ptr = (g+1) mod N_REQ.
  - Back-to-back packets from different requesters are separated by exactly one IDLE cycle (two with header).
- Timeout:
  - The counter clears on every transfer and on entering DATA.
  - It increments each DATA cycle with !req_valid[g]; a cycle with valid but fifo_full does not count, since a full FIFO is not a requester stall.
  - When the counter reaches TIMEOUT-1 and the owner is still not valid: timeout_pulse = 1 for one cycle, go to IDLE, rr_ptr = (g+1) mod N_REQ.
  - The packet is truncated; no terminator byte is written.
- Simultaneous events:
  - Transfer with last on the same cycle as the timeout condition cannot occur, because a transfer requires valid.
  - A requester dropping valid in IDLE before the grant registers is harmless: the arbiter enters HDR/DATA and then times out if it stays low.
- Ordering and integrity:
  - fifo_wr is never asserted while fifo_full = 1.
  - At most one byte is written per cycle.
  - Bytes of a packet are never interleaved with those of another requester.
  - A single-byte packet (valid & last on the first byte) is legal.
- Arithmetic:
  - rr_ptr and grant_id wrap modulo N_REQ; for non-power-of-2 N_REQ, an increment from N_REQ-1 goes to 0.
  - Counter width is $clog2(TIMEOUT)+1; it saturates and does not wrap.

Test Plan:
- Basic packet (ID_EN=1, fifo_full=0): req 2 sends 3 bytes 0x11,0x22,0x33 with last on 0x33 -> FIFO receives 0xA2,0x11,0x22,0x33 on consecutive cycles; busy high for 4 cycles; rr_ptr = 3.
- Round-robin: all four requesters continuously valid with 1-byte packets, start rr_ptr = 0 -> header order A0,A1,A2,A3,A0; no requester granted twice before the others.
- Backpressure: fifo_full held high for 5 cycles mid-packet -> fifo_wr = 0 and req_ready = 0 throughout; no byte lost or duplicated; the timeout counter does not advance.
- Timeout (TIMEOUT=8): owner 1 sends 0x55 (not last) then drops valid -> timeout_pulse exactly 8 DATA cycles later; state IDLE; a pending requester 2 is granted next.
- ID_EN=0, N_REQ=3: requesters 0 and 2 valid, rr_ptr = 1 -> requester 2 granted first; no header byte; rr_ptr wraps to 0 after its last byte.
- Reset during DATA after 2 of 4 bytes -> next cycle busy = 0, fifo_wr = 0, grant_id = 0, req_ready = 0; a new request is served normally afterwards.
